factorial_scheduler: RTL
========================

# factorial_scheduler

Round-robin scheduler that shares one factorial datapath (N register with decrement, 17-bit R register with multiply-load, N==0 flag) among NREQ requesters. It arbitrates requests, steers the winner's operand into the datapath, sequences the load/multiply/decrement strobes, and returns the registered result with a per-requester done pulse. It sits between requester blocks and the single factorial datapath instance and replaces a dedicated control path per requester.

## Interface
- NREQ, 4, number of requesters
- DW, 8, operand width
- RW, 17, result width
- MAXN, 8, largest accepted operand (8! = 40320 fits RW=17); the integrator guarantees MAXN! < 2^RW; the block does not check this

- Clk  in  1  clock, rising edge
- Rst  in  1  reset; synchronous, active-high
- Req  in  NREQ  request per requester, level
- Din  in  NREQ*DW  operand of requester i on Din[i*DW +: DW]
- Gnt  out  NREQ  one-hot grant, combinational, IDLE only
- Done  out  NREQ  one-hot, registered, one-cycle completion pulse
- Err  out  1  registered; qualifies Done: operand > MAXN
- Res  out  RW  registered result, held until next Done
- Busy  out  1  registered; high while a job occupies the datapath
- DpLdN  out  1  datapath N <= DpDin
- DpClr  out  1  datapath R <= 1
- DpLdR  out  1  datapath R <= R*N (uses pre-edge N)
- DpDecN  out  1  datapath N <= N-1
- DpDin  out  DW  operand to datapath; winner's Din in grant cycle, else 0
- DpZero  in  1  datapath N==0, combinational
- DpR  in  RW  datapath R register

## Operation
- Two states: IDLE, LOOP. Owner register holds the index of the granted requester.
- Round-robin pointer Last (reset NREQ-1): priority scans Last+1, Last+2, … mod NREQ; first requester with Req high wins.
- IDLE, no Req: all strobes 0, stay IDLE.
- IDLE, winner w, Din[w] <= MAXN: Gnt[w]=1, DpDin=Din[w], DpLdN=DpClr=1. Edge: Owner<=w, Last<=w, Busy<=1, to LOOP.
- IDLE, winner w, Din[w] > MAXN: Gnt[w]=1, no datapath strobes. Edge: Last<=w, Done[w]<=1, Err<=1, Res<=0, stay IDLE.
- LOOP, DpZero=0: DpLdR=DpDecN=1 together.
- LOOP, DpZero=1: no strobes. Edge: Res<=DpR, Done[Owner]<=1, Err<=0, Busy<=0, to IDLE.
- Done/Err are single-cycle pulses. Res holds its value otherwise.
- Requester protocol: hold Req[i] and Din[i] stable until Gnt[i]; drop Req[i] the following cycle; do not re-raise before Done[i]. Req is sampled only in IDLE; requests during LOOP wait.
- Operand 0 gives Res=1 (0! = 1).
- Rst: next state IDLE, Last=NREQ-1, Owner=0, Done=0, Err=0, Res=0, Busy=0. All Dp strobes and Gnt are 0 in any cycle with Rst=1. An aborted job produces no Done. Datapath contents are not cleared; the next grant's DpLdN/DpClr reinitialise them.

## Timing
- Grant cycle = cycle 0. Valid operand N: LOOP during cycles 1..N+1 (N multiply cycles, then one zero-detect cycle). Done, Res and Busy fall are visible in cycle N+2.
- Cycle N+2 is IDLE, so a new grant can issue in the same cycle as Done (back-to-back). The datapath is occupied N+2 cycles per job.
- Rejected operand: Done+Err in cycle 1. Arbitration also runs in cycle 1.
- Gnt is combinational from Req/Last/state. All other outputs except the Dp strobes/DpDin are registered.

## Test plan
- Single job: Req[0]=1, Din[0]=5 at cycle 0 -> Gnt[0] cycle 0, DpLdR/DpDecN high cycles 1-5, Done[0]=1 and Res=120 in cycle 7, Err=0.
- Edge operands: Din=0 -> Done cycle 2, Res=1. Din=8 -> Done cycle 10, Res=40320. Din=9 -> Done cycle 1, Err=1, Res=0, no Dp strobe ever asserted.
- Contention: Req[3:0] all raised together with Din = 3,4,5,6 after reset -> grant order 0,1,2,3 at cycles 0,5,11,18. Results 6, 24, 120, 720 on the matching Done bits.
- Fairness: requester 0 re-raises Req immediately after each Done, requester 2 holds Req; both use N=2 -> grants alternate 0,2,0,2; requester 2 never waits more than one job.
- Reset mid-job: Din[1]=6 granted, Rst=1 for one cycle at cycle 3 -> no Done, Busy=0 and state IDLE the next cycle. The next Req[1], Din=4, gives Res=24 and is granted first (Last reset).
- Back-to-back: Req[1] held with N=1 while Done[0] pulses -> Gnt[1] in the same cycle as Done[0]. DpLdN and DpClr are high in that cycle.

Source files
------------

// File: rtl/factorial_scheduler_if.sv
// Requester and datapath signal bundle for factorial_scheduler.
// slave is the scheduler's view; master is the requester/datapath side.
interface factorial_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int RW   = 17
);
  logic [NREQ-1:0]    Req;
  logic [NREQ*DW-1:0] Din;
  logic [NREQ-1:0]    Gnt;
  logic [NREQ-1:0]    Done;
  logic               Err;
  logic [RW-1:0]      Res;
  logic               Busy;
  logic               DpLdN;
  logic               DpClr;
  logic               DpLdR;
  logic               DpDecN;
  logic [DW-1:0]      DpDin;
  logic               DpZero;
  logic [RW-1:0]      DpR;

  modport slave (
    input  Req, Din, DpZero, DpR,
    output Gnt, Done, Err, Res, Busy, DpLdN, DpClr, DpLdR, DpDecN, DpDin
  );

  modport master (
    output Req, Din, DpZero, DpR,
    input  Gnt, Done, Err, Res, Busy, DpLdN, DpClr, DpLdR, DpDecN, DpDin
  );
endinterface

// File: rtl/factorial_scheduler.sv
// Round-robin scheduler sharing one factorial datapath; a job on operand N takes N+2 cycles, Done in cycle N+2.
// Requests are only sampled in IDLE; later requesters simply wait (Req held) until the datapath frees up.
module factorial_scheduler #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int RW   = 17,
  parameter int MAXN = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  factorial_scheduler_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, LOOP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   last, owner;
  logic [IW-1:0]   cand, win;
  logic            found;
  logic [DW-1:0]   win_din;
  logic            reject;

  logic [NREQ-1:0] gnt;
  logic            dp_ldn, dp_clr, dp_ldr, dp_decn;
  logic [DW-1:0]   dp_din;

  logic [NREQ-1:0] done_q;
  logic            err_q;
  logic [RW-1:0]   res_q;
  logic            busy_q;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    onehot = NREQ'(1) << i;
  endfunction

  // Scan Last+1, Last+2, ... with wrap, so the previous winner has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = last;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IW'(NREQ - 1)) ? '0 : cand + IW'(1);
      if (!found && bus.Req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) win_din = bus.Din[i*DW +: DW];
    end
    reject = (win_din > DW'(MAXN));
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    dp_ldn    = 1'b0;
    dp_clr    = 1'b0;
    dp_ldr    = 1'b0;
    dp_decn   = 1'b0;
    dp_din    = '0;
    if (!Rst) begin
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt = onehot(win);
            if (!reject) begin
              dp_din    = win_din;
              dp_ldn    = 1'b1;
              dp_clr    = 1'b1;
              state_nxt = LOOP;
            end
          end
        end
        LOOP: begin
          // The zero-detect cycle issues no strobes; R already holds N!.
          if (!bus.DpZero) begin
            dp_ldr  = 1'b1;
            dp_decn = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      last   <= IW'(NREQ - 1);
      owner  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
      res_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      if (state == IDLE && found) begin
        last <= win;
        if (reject) begin
          done_q <= onehot(win);
          err_q  <= 1'b1;
          res_q  <= '0;
        end else begin
          owner  <= win;
          busy_q <= 1'b1;
        end
      end else if (state == LOOP && bus.DpZero) begin
        res_q  <= bus.DpR;
        done_q <= onehot(owner);
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.Gnt    = gnt;
  assign bus.DpLdN  = dp_ldn;
  assign bus.DpClr  = dp_clr;
  assign bus.DpLdR  = dp_ldr;
  assign bus.DpDecN = dp_decn;
  assign bus.DpDin  = dp_din;
  assign bus.Done   = done_q;
  assign bus.Err    = err_q;
  assign bus.Res    = res_q;
  assign bus.Busy   = busy_q;

  a_gnt_onehot:  assert property (@(posedge Clk) disable iff (Rst) $onehot0(gnt));
  a_done_onehot: assert property (@(posedge Clk) disable iff (Rst) $onehot0(done_q));
  a_mul_dec:     assert property (@(posedge Clk) disable iff (Rst) dp_ldr == dp_decn);

endmodule
